ula_arbiter: RTL and testbench

ULA_ARBITER -- requirements
Module: ula_arbiter

---
 rtl/ula_arbiter.sv | 155 +++++++++++++++
 tb/tb_ula_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ula_arbiter.sv
// ula_arbiter: two requesters share a single add/compare unit (ula).
// A round-robin arbiter picks one operation per cycle whenever the
// response register is free; the result and flags are registered and
// handed to the consumer with a valid/ready handshake.

// ula: combinational adder / comparator with five relational flags.
module ula #(
  parameter int SIZE = 64
) (
  input  logic [SIZE-1:0] s1,
  input  logic [SIZE-1:0] s2,
  input  logic            sub,
  output logic [SIZE-1:0] res,
  output logic [4:0]      flags
);

  logic [SIZE:0] sum;
  logic          carry;
  logic          eq;
  logic          lt_sn;
  logic          gt_un;

  // Subtraction is s1 + ~s2 + 1, so carry-out set means s1 >= s2 (unsigned)
  always_comb begin
    sum = {1'b0, s1} + {1'b0, (sub ? ~s2 : s2)} + {{SIZE{1'b0}}, sub};
    res = sum[SIZE-1:0];
    carry = sum[SIZE];
    eq = (res == '0);
    lt_sn = (s1[SIZE-1] != s2[SIZE-1]) ? s1[SIZE-1] : res[SIZE-1];
    gt_un = carry & ~eq;
    flags = {eq, ~eq & ~lt_sn, lt_sn, gt_un, ~gt_un & ~eq};
  end

endmodule

module ula_arbiter #(
  parameter int SIZE = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [SIZE-1:0] req0_s1,
  input  logic [SIZE-1:0] req0_s2,
  input  logic            req0_sub,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [SIZE-1:0] req1_s1,
  input  logic [SIZE-1:0] req1_s2,
  input  logic            req1_sub,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [SIZE-1:0] rsp_res,
  output logic [4:0]      rsp_flags,
  output logic [15:0]     grant_cnt0,
  output logic [15:0]     grant_cnt1
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state;
  state_t          state_next;
  logic            last_grant;
  logic            granted0;
  logic            granted1;
  logic            free;
  logic            accept0;
  logic            accept1;
  logic            accept;
  logic [SIZE-1:0] alu_s1;
  logic [SIZE-1:0] alu_s2;
  logic            alu_sub;
  logic [SIZE-1:0] alu_res;
  logic [4:0]      alu_flags;

  // Round-robin pick: a lone requester wins; on contention the one not served last wins
  always_comb begin
    granted0 = req0_valid & (~req1_valid | last_grant);
    granted1 = req1_valid & (~req0_valid | ~last_grant);
  end

  // Route the granted requester's operands into the shared unit
  always_comb begin
    alu_s1  = granted1 ? req1_s1  : req0_s1;
    alu_s2  = granted1 ? req1_s2  : req0_s2;
    alu_sub = granted1 ? req1_sub : req0_sub;
  end

  ula #(.SIZE(SIZE)) u_ula (
    .s1    (alu_s1),
    .s2    (alu_s2),
    .sub   (alu_sub),
    .res   (alu_res),
    .flags (alu_flags)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  // FSM next state: fill on acceptance, drain on a consume with nothing new arriving
  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (accept) state_next = FULL;
      FULL:    if (rsp_ready && !accept) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // FSM outputs: the register is free when empty or being consumed; readies are held low in reset
  always_comb begin
    rsp_valid  = (state == FULL);
    free       = ~rsp_valid | rsp_ready;
    req0_ready = granted0 & free & rst_n;
    req1_ready = granted1 & free & rst_n;
    accept0    = req0_valid & req0_ready;
    accept1    = req1_valid & req1_ready;
    accept     = accept0 | accept1;
  end

  // Response payload loads only on acceptance and otherwise holds its last value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_res   <= '0;
      rsp_flags <= '0;
      rsp_id    <= 1'b0;
    end else if (accept) begin
      rsp_res   <= alu_res;
      rsp_flags <= alu_flags;
      rsp_id    <= accept1;
    end
  end

  // Remember who was served last; reset value lets requester 0 win first contention
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_grant <= 1'b1;
    else if (accept) last_grant <= accept1;
  end

  // Per-requester acceptance counters, wrapping naturally at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (accept0) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (accept1) grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end

endmodule

// File: tb/tb_ula_arbiter.sv
// Directed testbench for ula_arbiter with hand-computed expectations.
module tb_ula_arbiter;

  localparam int SIZE = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req0_valid, req1_valid;
  logic            req0_ready, req1_ready;
  logic [SIZE-1:0] req0_s1, req0_s2, req1_s1, req1_s2;
  logic            req0_sub, req1_sub;
  logic            rsp_valid, rsp_ready, rsp_id;
  logic [SIZE-1:0] rsp_res;
  logic [4:0]      rsp_flags;
  logic [15:0]     grant_cnt0, grant_cnt1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ula_arbiter #(.SIZE(SIZE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_s1(req0_s1), .req0_s2(req0_s2), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_s1(req1_s1), .req1_s2(req1_s2), .req1_sub(req1_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_res(rsp_res), .rsp_flags(rsp_flags),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_s1 = '0; req0_s2 = '0; req0_sub = 0;
    req1_s1 = '0; req1_s2 = '0; req1_sub = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1; req1_valid = 1; rsp_ready = 1;
    #2;
    tests++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      fails++; $display("[TB] FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready});
    end
    tests++;
    if ({rsp_valid, rsp_id, rsp_res, rsp_flags, grant_cnt0, grant_cnt1} !== '0) begin
      fails++; $display("[TB] FAIL reset_state valid=%b id=%b res=%h flags=%b c0=%h c1=%h exp all zero",
                        rsp_valid, rsp_id, rsp_res, rsp_flags, grant_cnt0, grant_cnt1);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    req0_valid = 1; req0_s1 = 64'd5; req0_s2 = 64'd5; req0_sub = 1;
    #1;
    tests++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      fails++; $display("[TB] FAIL single_ready got=%b%b exp=10", req0_ready, req1_ready);
    end
    step();
    req0_valid = 0;
    tests++;
    if (rsp_valid !== 1 || rsp_id !== 0 || rsp_res !== 64'd0 || rsp_flags !== 5'b10000 || grant_cnt0 !== 16'd1) begin
      fails++; $display("[TB] FAIL single_rsp valid=%b id=%b res=%h flags=%b c0=%0d exp 1/0/0/10000/1",
                        rsp_valid, rsp_id, rsp_res, rsp_flags, grant_cnt0);
    end
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    tests++;
    if (rsp_valid !== 0 || rsp_res !== 64'd0 || rsp_flags !== 5'b10000) begin
      fails++; $display("[TB] FAIL consume_drain valid=%b res=%h flags=%b exp 0/0/10000",
                        rsp_valid, rsp_res, rsp_flags);
    end
  endtask

  task automatic test_contention();
    do_reset();
    rsp_ready = 1;
    req0_valid = 1; req0_s1 = '1; req0_s2 = 64'd1; req0_sub = 1;
    req1_valid = 1; req1_s1 = 64'd3; req1_s2 = 64'd4; req1_sub = 0;
    step();
    req0_valid = 0;
    tests++;
    if (rsp_id !== 0 || rsp_res !== 64'hFFFF_FFFF_FFFF_FFFE || rsp_flags !== 5'b00110) begin
      fails++; $display("[TB] FAIL contention_edge1 id=%b res=%h flags=%b exp 0/fffffffffffffffe/00110",
                        rsp_id, rsp_res, rsp_flags);
    end
    step();
    req1_valid = 0;
    tests++;
    if (rsp_valid !== 1 || rsp_id !== 1 || rsp_res !== 64'd7) begin
      fails++; $display("[TB] FAIL contention_edge2 valid=%b id=%b res=%h exp 1/1/7", rsp_valid, rsp_id, rsp_res);
    end
    tests++;
    if (grant_cnt0 !== 16'd1 || grant_cnt1 !== 16'd1) begin
      fails++; $display("[TB] FAIL contention_counts c0=%0d c1=%0d exp 1/1", grant_cnt0, grant_cnt1);
    end
  endtask

  task automatic test_back_pressure();
    do_reset();
    req0_valid = 1; req0_s1 = 64'd10; req0_s2 = 64'd3; req0_sub = 0;
    step();
    req0_s1 = 64'd20; req0_s2 = 64'd1;
    req1_valid = 1; req1_s1 = 64'd100; req1_s2 = 64'd50; req1_sub = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++;
      if ({req0_ready, req1_ready} !== 2'b00 || rsp_valid !== 1 || rsp_id !== 0 || rsp_res !== 64'd13) begin
        fails++; $display("[TB] FAIL backpressure_c%0d rdy=%b%b valid=%b id=%b res=%h exp 00/1/0/d",
                          c, req0_ready, req1_ready, rsp_valid, rsp_id, rsp_res);
      end
      step();
    end
    rsp_ready = 1;
    #1;
    tests++;
    if (req0_ready !== 0 || req1_ready !== 1) begin
      fails++; $display("[TB] FAIL backpressure_release rdy=%b%b exp 01", req0_ready, req1_ready);
    end
    step();
    req1_valid = 0; req0_valid = 0; rsp_ready = 0;
    tests++;
    if (rsp_valid !== 1 || rsp_id !== 1 || rsp_res !== 64'd50 || grant_cnt1 !== 16'd1) begin
      fails++; $display("[TB] FAIL backpressure_next valid=%b id=%b res=%h c1=%0d exp 1/1/32/1",
                        rsp_valid, rsp_id, rsp_res, grant_cnt1);
    end
  endtask

  task automatic test_round_robin();
    logic exp_id;
    do_reset();
    rsp_ready = 1;
    req0_valid = 1; req0_s1 = 64'd1; req0_s2 = 64'd2; req0_sub = 0;
    req1_valid = 1; req1_s1 = 64'd9; req1_s2 = 64'd4; req1_sub = 1;
    exp_id = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      tests++;
      if (req0_ready !== ~exp_id || req1_ready !== exp_id) begin
        fails++; $display("[TB] FAIL rr_grant_c%0d rdy=%b%b exp=%b%b", c, req0_ready, req1_ready, ~exp_id, exp_id);
      end
      step();
      tests++;
      if (rsp_id !== exp_id || rsp_res !== (exp_id ? 64'd5 : 64'd3)) begin
        fails++; $display("[TB] FAIL rr_rsp_c%0d id=%b res=%h exp id=%b", c, rsp_id, rsp_res, exp_id);
      end
      exp_id = ~exp_id;
    end
    req0_valid = 0; req1_valid = 0;
    tests++;
    if (grant_cnt0 !== 16'd4 || grant_cnt1 !== 16'd4) begin
      fails++; $display("[TB] FAIL rr_counts c0=%0d c1=%0d exp 4/4", grant_cnt0, grant_cnt1);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req0_valid = 1; req0_s1 = 64'd7; req0_s2 = 64'd2; req0_sub = 1;
    step();
    req0_valid = 0;
    tests++;
    if (rsp_valid !== 1 || rsp_res !== 64'd5) begin
      fails++; $display("[TB] FAIL async_pre valid=%b res=%h exp 1/5", rsp_valid, rsp_res);
    end
    #2;
    rst_n = 0;
    #1;
    tests++;
    if (rsp_valid !== 0 || grant_cnt0 !== 0 || grant_cnt1 !== 0 || rsp_res !== '0) begin
      fails++; $display("[TB] FAIL async_reset valid=%b c0=%0d c1=%0d res=%h exp all zero",
                        rsp_valid, grant_cnt0, grant_cnt1, rsp_res);
    end
    @(negedge clk);
    rst_n = 1;
    rsp_ready = 1;
    req0_valid = 1; req0_s1 = 64'd1; req0_s2 = 64'd1; req0_sub = 0;
    req1_valid = 1; req1_s1 = 64'd2; req1_s2 = 64'd2; req1_sub = 0;
    #1;
    tests++;
    if (req0_ready !== 1 || req1_ready !== 0) begin
      fails++; $display("[TB] FAIL async_first_grant rdy=%b%b exp 10", req0_ready, req1_ready);
    end
    step();
    req0_valid = 0; req1_valid = 0;
    tests++;
    if (rsp_id !== 0 || rsp_res !== 64'd2 || grant_cnt0 !== 16'd1) begin
      fails++; $display("[TB] FAIL async_first_rsp id=%b res=%h c0=%0d exp 0/2/1", rsp_id, rsp_res, grant_cnt0);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    rsp_ready = 1;
    req1_valid = 1; req1_s1 = 64'd1; req1_s2 = 64'd1; req1_sub = 0;
    for (int c = 0; c < 65535; c++) step();
    tests++;
    if (grant_cnt1 !== 16'hFFFF || grant_cnt0 !== 16'h0000) begin
      fails++; $display("[TB] FAIL wrap_preload c1=%h c0=%h exp ffff/0000", grant_cnt1, grant_cnt0);
    end
    step();
    req1_valid = 0;
    tests++;
    if (grant_cnt1 !== 16'h0000) begin
      fails++; $display("[TB] FAIL wrap_roll c1=%h exp 0000", grant_cnt1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_pressure();
    test_round_robin();
    test_async_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
